fdiv_sqrt_ctl: RTL

FDIV_SQRT_CTL -- requirements
Module: fdiv_sqrt_ctl

---
 rtl/fdiv_ctl_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/fdiv_sqrt_ctl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fdiv_ctl_pkg.sv
// Shared state encoding, operand record and sizing for the FP divide/sqrt issue controller.
package fdiv_ctl_pkg;

  localparam int DEF_TAG_W   = 5;
  localparam int DEF_TIMEOUT = 127;
  localparam int DATA_W      = 65;
  localparam int FLAG_W      = 5;
  localparam int RM_W        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    HOLD  = 2'd3
  } ctlState_t;

  typedef struct packed {
    logic              sqrt;
    logic              fp64;
    logic [RM_W-1:0]   rm;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } divOp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, zero unless enabled; a lone requester always wins.
// On a tie the requester that did not win last time is granted; the winner register updates on every grant.
module rr_arb2 (
  input  logic       clock,
  input  logic       nReset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic lastGrant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) begin
        grant = lastGrant ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

  // Resetting to pipe 1 makes pipe 0 the winner of the first tie.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      lastGrant <= 1'b1;
    end else if (|grant) begin
      lastGrant <= grant[1];
    end
  end

endmodule

// File: rtl/fdiv_sqrt_ctl.sv
// Issue/writeback controller for one shared FP div/sqrt unit fed by two pipes, one op in flight.
// Accept->issue 1 cycle, result->wb_valid 1 cycle; stalls on div_inReady/wb_ready; flush_lower kills the op.
module fdiv_sqrt_ctl
  import fdiv_ctl_pkg::*;
#(
  parameter int TAG_W   = DEF_TAG_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              nReset,

  input  logic              i0_valid,
  output logic              i0_ready,
  input  logic              i0_sqrt,
  input  logic              i0_fp64,
  input  logic [RM_W-1:0]   i0_rm,
  input  logic [DATA_W-1:0] i0_a,
  input  logic [DATA_W-1:0] i0_b,
  input  logic [TAG_W-1:0]  i0_tag,

  input  logic              i1_valid,
  output logic              i1_ready,
  input  logic              i1_sqrt,
  input  logic              i1_fp64,
  input  logic [RM_W-1:0]   i1_rm,
  input  logic [DATA_W-1:0] i1_a,
  input  logic [DATA_W-1:0] i1_b,
  input  logic [TAG_W-1:0]  i1_tag,

  input  logic              flush_lower,

  output logic              div_inValid,
  output logic              div_sqrtOp,
  output logic              div_fp64,
  output logic [RM_W-1:0]   div_rm,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  output logic              div_flush,
  input  logic              div_inReady,
  input  logic              div_outValid,
  input  logic [DATA_W-1:0] div_data,
  input  logic [FLAG_W-1:0] div_flags,

  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [DATA_W-1:0] wb_data,
  output logic [FLAG_W-1:0] wb_flags,

  output logic              busy,
  output logic              timeout_err,
  output logic              spurious_err
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  ctlState_t         state;
  ctlState_t         stateNxt;
  divOp_t            opReg;
  divOp_t            opNxt;
  logic [TAG_W-1:0]  tagReg;
  logic [TAG_W-1:0]  tagNxt;
  logic [DATA_W-1:0] wbDataReg;
  logic [FLAG_W-1:0] wbFlagsReg;
  logic [CNT_W-1:0]  cnt;
  logic              timeoutErrReg;
  logic              spuriousErrReg;

  logic [1:0]        grant;
  logic              arbEnable;
  logic              captureResult;
  logic              timeoutHit;
  logic              flushUnit;

  // Gating with nReset keeps the ready outputs low while reset is held.
  assign arbEnable = nReset && (state == IDLE) && !flush_lower;

  rr_arb2 uArb (
    .clock  (clock),
    .nReset (nReset),
    .enable (arbEnable),
    .req    ({i1_valid, i0_valid}),
    .grant  (grant)
  );

  assign i0_ready = grant[0];
  assign i1_ready = grant[1];

  always_comb begin
    opNxt  = '{sqrt: i0_sqrt, fp64: i0_fp64, rm: i0_rm, a: i0_a, b: i0_b};
    tagNxt = i0_tag;
    if (grant[1]) begin
      opNxt  = '{sqrt: i1_sqrt, fp64: i1_fp64, rm: i1_rm, a: i1_a, b: i1_b};
      tagNxt = i1_tag;
    end
  end

  always_comb begin
    stateNxt      = state;
    flushUnit     = 1'b0;
    timeoutHit    = 1'b0;
    captureResult = 1'b0;
    unique case (state)
      IDLE: begin
        if (|grant) stateNxt = ISSUE;
      end
      ISSUE: begin
        if (flush_lower) begin
          stateNxt = IDLE;
        end else if (div_inReady) begin
          stateNxt = BUSY;
        end
      end
      BUSY: begin
        // A flush beats a same-cycle result; a result arriving on the last allowed cycle beats the timeout.
        if (flush_lower) begin
          flushUnit = 1'b1;
          stateNxt  = IDLE;
        end else if (div_outValid) begin
          captureResult = 1'b1;
          stateNxt      = HOLD;
        end else if (cnt == CNT_MAX) begin
          flushUnit  = 1'b1;
          timeoutHit = 1'b1;
          stateNxt   = IDLE;
        end
      end
      HOLD: begin
        if (flush_lower || wb_ready) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state          <= IDLE;
      opReg          <= '0;
      tagReg         <= '0;
      wbDataReg      <= '0;
      wbFlagsReg     <= '0;
      cnt            <= '0;
      timeoutErrReg  <= 1'b0;
      spuriousErrReg <= 1'b0;
    end else begin
      state <= stateNxt;
      if (|grant) begin
        opReg  <= opNxt;
        tagReg <= tagNxt;
      end
      if (state != BUSY) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (captureResult) begin
        wbDataReg  <= div_data;
        wbFlagsReg <= div_flags;
      end
      if (timeoutHit) timeoutErrReg <= 1'b1;
      if (div_outValid && (state != BUSY)) spuriousErrReg <= 1'b1;
    end
  end

  // Suppressing the request on a flush cycle keeps the unit from accepting an op we are dropping.
  assign div_inValid  = (state == ISSUE) && !flush_lower;
  assign div_sqrtOp   = opReg.sqrt;
  assign div_fp64     = opReg.fp64;
  assign div_rm       = opReg.rm;
  assign div_a        = opReg.a;
  assign div_b        = opReg.b;
  assign div_flush    = flushUnit;

  assign wb_valid     = (state == HOLD) && !flush_lower;
  assign wb_tag       = tagReg;
  assign wb_data      = wbDataReg;
  assign wb_flags     = wbFlagsReg;

  assign busy         = (state != IDLE);
  assign timeout_err  = timeoutErrReg;
  assign spurious_err = spuriousErrReg;

endmodule
